fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port stall  input  1  SHALL be high when the IF/ID register does not accept (IF_ID_regwrite low).
REQ-005 Port redirect  input  1  SHALL be high for one cycle per branch/jump taken.
REQ-006 Port redirect_pc  input  32  SHALL be the new fetch address, sampled when redirect is high.
REQ-007 Port imem_req  output  1  SHALL be high while a memory read is outstanding.
REQ-008 Port imem_addr  output  32  SHALL be the read address, word-aligned.
REQ-009 Port imem_ready  input  1  SHALL be high for one cycle when imem_rdata is valid.
REQ-010 Port imem_rdata  input  32  SHALL be the instruction word.
REQ-011 Port pcF  output  32  SHALL be the address of the presented instruction.
REQ-012 Port pc4F  output  32  SHALL be pcF+4.
REQ-013 Port InstF  output  32  SHALL be the presented instruction.
REQ-014 Port fetch_valid  output  1  SHALL be high while pcF/pc4F/InstF hold an unconsumed instruction.

Function
REQ-015 FSM states IDLE, REQ, HOLD, DISCARD; IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-016 Internal pc register SHALL hold the next fetch address; imem_addr SHALL come from a separate req_addr register loaded from pc on entry to REQ.
REQ-017 In REQ and DISCARD, imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_ready; in IDLE and HOLD, imem_req SHALL be 0.
REQ-018 REQ with imem_ready and no redirect: InstF<=imem_rdata, pcF<=req_addr, pc4F<=req_addr+4, fetch_valid<=1, pc<=req_addr+4, next state HOLD.
REQ-019 HOLD with stall=0: the instruction SHALL count as consumed at that edge; fetch_valid<=0, next state REQ.
REQ-020 HOLD with stall=1: all outputs SHALL hold unchanged, state stays HOLD, for any number of cycles.
REQ-021 redirect SHALL take priority over stall and imem_ready; it SHALL always set pc<=redirect_pc and fetch_valid<=0.
REQ-022 redirect in IDLE or HOLD: next state REQ, fetching redirect_pc.
REQ-023 redirect in REQ with imem_ready in the same cycle: returned data SHALL be dropped; next state REQ at redirect_pc.
REQ-024 redirect in REQ without imem_ready: next state DISCARD; imem_addr SHALL keep the old address.
REQ-025 DISCARD: on imem_ready, the data SHALL be dropped and the next state SHALL be REQ at the current pc; a further redirect in DISCARD SHALL only update pc.
REQ-026 All address arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC+4 = 0); redirect_pc[1:0] SHALL be forced to 0.
REQ-027 The unit SHALL have at most one outstanding memory request at any time.

Reset
REQ-028 While rst=0: state IDLE, pc=RESET_PC, req_addr=0, pcF=0, pc4F=0, InstF=0, fetch_valid=0, imem_req=0, asynchronously.
REQ-029 Reset asserted mid-request SHALL abandon the request; after release, the first fetch SHALL be RESET_PC.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the constant 4 (PC increment) and the NOP encoding 32'h0000_0013.
REQ-031 The design SHALL be one module with no sub-modules; the pc+4 adder SHALL be shared by the pc and pc4F paths.

Verification
REQ-032 Reset release, zero-wait memory returning 32'hAAAA_0001 at address 0 -> imem_addr=0 in cycle 2; pcF=0, pc4F=4, InstF=32'hAAAA_0001, fetch_valid=1 in cycle 3.
REQ-033 stall=1 for 5 cycles in HOLD -> outputs frozen and imem_req=0 throughout; stall=0 -> next imem_addr=4.
REQ-034 redirect to 32'h0000_0100 during HOLD -> fetch_valid falls next cycle; the next request is to 32'h100.
REQ-035 redirect to 32'h200 while a request to 8 waits 3 cycles -> imem_addr stays 8 until ready, data dropped, fetch_valid stays 0, next request to 32'h200.
REQ-036 RESET_PC=32'hFFFF_FFFC, one fetch -> pc4F=0 and the next request is to address 0.
REQ-037 rst pulled low while imem_req=1 -> imem_req=0 and fetch_valid=0 immediately; after release, the next request is to RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // PC increment between sequential instructions
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // Canonical NOP encoding (addi x0, x0, 0)
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem read, presents the fetched
// instruction until IF/ID accepts it, and squashes in-flight reads on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pcF,
  output logic [XLEN-1:0] pc4F,
  output logic [XLEN-1:0] InstF,
  output logic            fetch_valid
);

  state_t          state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] req_addr_d;
  logic [XLEN-1:0] pcf_d, pc4f_d, inst_d;
  logic            valid_d;
  logic            imem_req_d;
  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] redirect_addr;

  // Single incrementer feeding both the next pc and pc4F
  assign pc_sum        = imem_addr + PC_INC;
  assign redirect_addr = redirect_pc & ~(XLEN'(3));

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    req_addr_d = imem_addr;
    pcf_d      = pcF;
    pc4f_d     = pc4F;
    inst_d     = InstF;
    valid_d    = fetch_valid;

    if (redirect) begin
      pc_d    = redirect_addr;
      valid_d = 1'b0;
      unique case (state)
        ST_IDLE, ST_HOLD:   state_d = ST_REQ;
        ST_REQ, ST_DISCARD: state_d = imem_ready ? ST_REQ : ST_DISCARD;
        default:            state_d = ST_IDLE;
      endcase
    end else begin
      unique case (state)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ready) begin
            inst_d  = imem_rdata;
            pcf_d   = imem_addr;
            pc4f_d  = pc_sum;
            pc_d    = pc_sum;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            valid_d = 1'b0;
            state_d = ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (imem_ready) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A new request address is latched on every entry into REQ
    if ((state_d == ST_REQ) && ((state != ST_REQ) || redirect)) begin
      req_addr_d = pc_d;
    end

    imem_req_d = (state_d == ST_REQ) || (state_d == ST_DISCARD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      imem_addr   <= '0;
      imem_req    <= 1'b0;
      pcF         <= '0;
      pc4F        <= '0;
      InstF       <= '0;
      fetch_valid <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      imem_addr   <= req_addr_d;
      imem_req    <= imem_req_d;
      pcF         <= pcf_d;
      pc4F        <= pc4f_d;
      InstF       <= inst_d;
      fetch_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model checks
// request addresses, a monitor checks every presented instruction.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pcF, pc4F, InstF;
  logic        fetch_valid;

  // Second instance exercising address wrap
  logic        stall1;
  logic        imem_req1, imem_ready1, fetch_valid1;
  logic [31:0] imem_addr1, imem_rdata1, pcF1, pc4F1, InstF1;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 0;
  int wait_cnt = 0;
  logic [31:0] cur_addr;
  logic        prev_fv = 1'b0;

  logic [31:0] exp_addr[$];
  fetch_t      exp_fetch[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pcF(pcF), .pc4F(pc4F),
    .InstF(InstF), .fetch_valid(fetch_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall1), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_ready(imem_ready1), .imem_rdata(imem_rdata1), .pcF(pcF1), .pc4F(pc4F1),
    .InstF(InstF1), .fetch_valid(fetch_valid1)
  );

  assign imem_ready1 = imem_req1;
  assign imem_rdata1 = 32'h1234_5678;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic fetch_t mk(input logic [31:0] pc, input logic [31:0] inst);
    fetch_t f;
    f.pc = pc; f.pc4 = pc + 32'd4; f.inst = inst;
    return f;
  endfunction

  // Memory model: answers after lat wait cycles, checks address order and stability
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt == 0) cur_addr = imem_addr;
      else check("addr_stable", imem_addr, cur_addr);
      if (wait_cnt == lat) begin
        imem_ready = 1'b1;
        imem_rdata = 32'hAAAA_0001 + imem_addr;
        wait_cnt   = 0;
        if (exp_addr.size() == 0) check("addr_unexpected", imem_addr, 32'hxxxx_xxxx);
        else check("req_addr", imem_addr, exp_addr.pop_front());
      end else begin
        imem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ready = 1'b0;
      wait_cnt   = 0;
    end
  end

  // Monitor: each new presentation is compared against the scoreboard
  always @(negedge clk) begin
    if (fetch_valid && !prev_fv) begin
      if (exp_fetch.size() == 0) begin
        check("fetch_unexpected", pcF, 32'hxxxx_xxxx);
      end else begin
        fetch_t e;
        e = exp_fetch.pop_front();
        check("pcF", pcF, e.pc);
        check("pc4F", pc4F, e.pc4);
        check("InstF", InstF, e.inst);
      end
    end
    prev_fv = fetch_valid;
  end

  task automatic wait_fv(input string name);
    int k = 0;
    while (!fetch_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(fetch_valid), 32'd1);
  endtask

  initial begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    rst = 1'b0; stall = 1'b1; stall1 = 1'b1; redirect = 1'b0; redirect_pc = '0;

    // Reset values
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    check("rst_pcF", pcF, 32'd0);
    check("rst_InstF", InstF, 32'd0);
    check("rst_addr", imem_addr, 32'd0);

    // First fetch after reset at address 0
    exp_addr.push_back(32'h0);
    exp_fetch.push_back(mk(32'h0, 32'hAAAA_0001));
    rst = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("first_fv", 32'(fetch_valid), 32'd1);

    // Stall holds everything and issues no request
    repeat (5) begin
      @(negedge clk);
      check("stall_fv", 32'(fetch_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_pcF", pcF, 32'h0);
      check("stall_inst", InstF, 32'hAAAA_0001);
    end
    exp_addr.push_back(32'h4);
    exp_fetch.push_back(mk(32'h4, 32'hAAAA_0005));
    stall = 1'b0;
    @(negedge clk);
    check("seq_req", 32'(imem_req), 32'd1);
    check("seq_addr", imem_addr, 32'h4);
    check("seq_fv", 32'(fetch_valid), 32'd0);
    stall = 1'b1;
    @(negedge clk);
    check("seq_fv_rise", 32'(fetch_valid), 32'd1);

    // Redirect while holding an instruction
    exp_addr.push_back(32'h100);
    exp_fetch.push_back(mk(32'h100, 32'hAAAA_0101));
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    check("hold_redir_fv", 32'(fetch_valid), 32'd0);
    check("hold_redir_addr", imem_addr, 32'h100);
    wait_fv("hold_redir_fetch");

    // Redirect while a slow request is outstanding: old data discarded
    lat = 3;
    exp_addr.push_back(32'h8);
    redirect = 1'b1; redirect_pc = 32'h8;
    @(negedge clk);
    check("slow_addr", imem_addr, 32'h8);
    exp_addr.push_back(32'h200);
    exp_fetch.push_back(mk(32'h200, 32'hAAAA_0201));
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    repeat (3) begin
      check("discard_addr", imem_addr, 32'h8);
      check("discard_req", 32'(imem_req), 32'd1);
      check("discard_fv", 32'(fetch_valid), 32'd0);
      @(negedge clk);
    end
    check("after_discard_addr", imem_addr, 32'h200);
    check("after_discard_fv", 32'(fetch_valid), 32'd0);
    wait_fv("discard_fetch");

    // Redirect coincident with ready: returned word dropped, unaligned target
    lat = 0;
    exp_addr.push_back(32'h204);
    stall = 1'b0;
    @(negedge clk);
    check("coinc_addr", imem_addr, 32'h204);
    exp_addr.push_back(32'h300);
    exp_fetch.push_back(mk(32'h300, 32'hAAAA_0301));
    redirect = 1'b1; redirect_pc = 32'h303; stall = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    check("coinc_new_addr", imem_addr, 32'h300);
    check("coinc_fv", 32'(fetch_valid), 32'd0);
    wait_fv("coinc_fetch");

    // Reset in the middle of a request
    lat = 3;
    stall = 1'b0;
    @(negedge clk);
    check("mid_req", 32'(imem_req), 32'd1);
    check("mid_addr", imem_addr, 32'h304);
    stall = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_fv", 32'(fetch_valid), 32'd0);
    check("async_pcF", pcF, 32'd0);
    lat = 0;
    exp_addr.push_back(32'h0);
    exp_fetch.push_back(mk(32'h0, 32'hAAAA_0001));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rerst_addr", imem_addr, 32'h0);
    check("rerst_req", 32'(imem_req), 32'd1);
    wait_fv("rerst_fetch");

    // Wrap-around instance
    check("wrap_fv", 32'(fetch_valid1), 32'd1);
    check("wrap_pcF", pcF1, 32'hFFFF_FFFC);
    check("wrap_pc4F", pc4F1, 32'h0);
    check("wrap_inst", InstF1, 32'h1234_5678);
    stall1 = 1'b0;
    @(negedge clk);
    check("wrap_next_req", 32'(imem_req1), 32'd1);
    check("wrap_next_addr", imem_addr1, 32'h0);
    stall1 = 1'b1;

    repeat (3) @(negedge clk);
    check("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks done", n_checks);
    $fatal(1, "timeout");
  end

endmodule
